// File: rtl/ht_task_arbiter_pkg.sv
// Shared hash-table command type and derived constants used by the task arbiter slice.
package ht_task_arbiter_pkg;

  typedef enum logic [1:0] {
    INSERT = 2'd0,
    DELETE = 2'd1,
    SEARCH = 2'd2,
    NOP    = 2'd3
  } ht_cmd_t;

  localparam int HT_CMD_W = $bits(ht_cmd_t);

endpackage

// File: rtl/ht_task_arbiter_if.sv
// Task bus between the arbiter's output register and hash_table_top.
interface ht_task_arbiter_if
  import ht_task_arbiter_pkg::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
) ();

  logic                   ht_valid_o;
  logic                   ht_ready_i;
  logic [KEY_WIDTH-1:0]   ht_key_o;
  logic [VALUE_WIDTH-1:0] ht_value_o;
  ht_cmd_t                ht_cmd_o;

  modport master (
    output ht_valid_o, ht_key_o, ht_value_o, ht_cmd_o,
    input  ht_ready_i
  );

  modport slave (
    input  ht_valid_o, ht_key_o, ht_value_o, ht_cmd_o,
    output ht_ready_i
  );

endinterface

// File: rtl/ht_task_arbiter_cid_fifo.sv
// In-order FIFO of client ids for issued tasks; head is the owner of the next result.
module ht_cid_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ht_task_arbiter.sv
// Round-robin merge of client task streams into one registered hash-table task port,
// tracking the originating client of each in-flight task.
module ht_task_arbiter
  import ht_task_arbiter_pkg::*;
#(
  parameter  int KEY_WIDTH    = 32,
  parameter  int VALUE_WIDTH  = 16,
  parameter  int NUM_CLIENTS  = 2,
  parameter  int MAX_INFLIGHT = 8,
  localparam int CID_WIDTH    = $clog2(NUM_CLIENTS),
  localparam int CNT_WIDTH    = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_CLIENTS-1:0]             cl_valid_i,
  output logic [NUM_CLIENTS-1:0]             cl_ready_o,
  input  logic [NUM_CLIENTS*KEY_WIDTH-1:0]   cl_key_i,
  input  logic [NUM_CLIENTS*VALUE_WIDTH-1:0] cl_value_i,
  input  logic [NUM_CLIENTS*HT_CMD_W-1:0]    cl_cmd_i,
  ht_task_arbiter_if.master                  ht,
  input  logic                               res_valid_i,
  input  logic                               res_ready_i,
  output logic [CID_WIDTH-1:0]               res_cid_o,
  output logic [CNT_WIDTH-1:0]               inflight_o,
  output logic                               err_o
);

  typedef logic [CID_WIDTH-1:0] cid_t;

  cid_t ptr;
  cid_t gnt;
  logic gnt_any;
  logic load_ok;
  logic accept;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  int   idx;

  assign load_ok = !ht.ht_valid_o || ht.ht_ready_i;
  assign pop     = res_valid_i && res_ready_i;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    gnt     = ptr;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (int'(ptr) + k) % NUM_CLIENTS;
      if (!gnt_any && cl_valid_i[idx]) begin
        gnt     = cid_t'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  // A full id FIFO stalls intake even when a result pops in the same cycle.
  always_comb begin
    cl_ready_o = '0;
    if (gnt_any && load_ok && !fifo_full) cl_ready_o[gnt] = 1'b1;
  end

  assign accept = |cl_ready_o;

  // Output register stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ht.ht_valid_o <= 1'b0;
      ht.ht_key_o   <= '0;
      ht.ht_value_o <= '0;
      ht.ht_cmd_o   <= INSERT;
      ptr           <= cid_t'(NUM_CLIENTS - 1);
    end else if (accept) begin
      ht.ht_valid_o <= 1'b1;
      ht.ht_key_o   <= cl_key_i[int'(gnt)*KEY_WIDTH +: KEY_WIDTH];
      ht.ht_value_o <= cl_value_i[int'(gnt)*VALUE_WIDTH +: VALUE_WIDTH];
      ht.ht_cmd_o   <= ht_cmd_t'(cl_cmd_i[int'(gnt)*HT_CMD_W +: HT_CMD_W]);
      ptr           <= gnt;
    end else if (ht.ht_ready_i) begin
      ht.ht_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                err_o <= 1'b0;
    else if (pop && fifo_empty)  err_o <= 1'b1;
  end

  ht_cid_fifo #(
    .WIDTH (CID_WIDTH),
    .DEPTH (MAX_INFLIGHT)
  ) u_cid_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (accept),
    .din   (gnt),
    .pop   (pop),
    .head  (res_cid_o),
    .count (inflight_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_ht_task_arbiter.sv
// Bench for ht_task_arbiter: directed table, corner sequences and a randomized run
// against a queue-based reference model.
module tb_ht_task_arbiter;
  import ht_task_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int KW   = 32;
  localparam int VW   = 16;
  localparam int MAXI = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    cl_valid;
  logic [N-1:0]    cl_ready;
  logic [N*KW-1:0] cl_key;
  logic [N*VW-1:0] cl_value;
  logic [N*2-1:0]  cl_cmd;
  logic            rv, rr;
  logic [0:0]      res_cid;
  logic [3:0]      inflight;
  logic            err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: output register contents, last winner, queue of issued ids.
  bit          m_valid;
  logic [KW-1:0] m_key;
  logic [VW-1:0] m_val;
  logic [1:0]  m_cmd;
  int          m_ptr;
  int          q[$];
  bit          m_err;

  ht_task_arbiter_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) hif ();

  ht_task_arbiter #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_CLIENTS(N), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cl_valid_i(cl_valid), .cl_ready_o(cl_ready),
    .cl_key_i(cl_key), .cl_value_i(cl_value), .cl_cmd_i(cl_cmd),
    .ht(hif),
    .res_valid_i(rv), .res_ready_i(rr),
    .res_cid_o(res_cid), .inflight_o(inflight), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (cl_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = winner();
    if (w >= 0 && (!m_valid || hif.ht_ready_i) && q.size() < MAXI) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_key = '0; m_val = '0; m_cmd = '0;
    m_ptr = N - 1; q.delete(); m_err = 0;
  endtask

  task automatic model_update();
    int w;
    bit acc;
    w   = winner();
    acc = (w >= 0) && (!m_valid || hif.ht_ready_i) && (q.size() < MAXI);
    if (rv && rr) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (acc) begin
      m_valid = 1;
      m_key   = cl_key[w*KW +: KW];
      m_val   = cl_value[w*VW +: VW];
      m_cmd   = cl_cmd[w*2 +: 2];
      m_ptr   = w;
      q.push_back(w);
    end else if (hif.ht_ready_i) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_model();
    chk("cl_ready", cl_ready, exp_ready());
    chk("ht_valid", hif.ht_valid_o, m_valid);
    chk("ht_key", hif.ht_key_o, m_key);
    chk("ht_value", hif.ht_value_o, m_val);
    chk("ht_cmd", hif.ht_cmd_o, m_cmd);
    chk("inflight", inflight, q.size());
    chk("err", err, m_err);
    if (q.size() > 0) chk("res_cid", res_cid, q[0]);
  endtask

  // One clock: compare mid-cycle, advance model with the inputs seen at the edge.
  task automatic cycle(input bit use_model);
    @(negedge clk);
    if (use_model) compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_hv"}, hif.ht_valid_o, 0);
    chk({tag, "_key"}, hif.ht_key_o, 0);
    chk({tag, "_val"}, hif.ht_value_o, 0);
    chk({tag, "_cmd"}, hif.ht_cmd_o, 0);
    chk({tag, "_infl"}, inflight, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cid"}, res_cid, 0);
  endtask

  task automatic do_reset();
    cl_valid = '0; rv = 0; rr = 0; hif.ht_ready_i = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_fixed_data();
    cl_key   = {32'h02000000, 32'h01000000};
    cl_value = {16'h5678, 16'h1234};
    cl_cmd   = {SEARCH, SEARCH};
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  valid;
    bit          rdy;
    bit          pop;
    logic [1:0]  e_ready;
    bit          e_hv;
    int          e_infl;
    int          e_cid;
    logic [31:0] e_key;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // single client 0, then two clients alternating with one-per-cycle pops
    tbl[0]  = '{0, 2'b01, 1, 0, 2'b01, 0, 0, -1, 32'h0};
    tbl[1]  = '{0, 2'b00, 1, 0, 2'b00, 1, 1,  0, 32'h01000000};
    tbl[2]  = '{0, 2'b00, 1, 1, 2'b00, 0, 1,  0, 32'h0};
    tbl[3]  = '{0, 2'b00, 1, 0, 2'b00, 0, 0, -1, 32'h0};
    tbl[4]  = '{1, 2'b11, 1, 0, 2'b01, 0, 0, -1, 32'h0};
    tbl[5]  = '{0, 2'b11, 1, 0, 2'b10, 1, 1,  0, 32'h01000000};
    tbl[6]  = '{0, 2'b11, 1, 1, 2'b01, 1, 2,  0, 32'h02000000};
    tbl[7]  = '{0, 2'b11, 1, 1, 2'b10, 1, 2,  1, 32'h01000000};
    tbl[8]  = '{0, 2'b00, 1, 1, 2'b00, 1, 2,  0, 32'h02000000};
    tbl[9]  = '{0, 2'b00, 1, 1, 2'b00, 0, 1,  1, 32'h0};
    tbl[10] = '{0, 2'b00, 1, 0, 2'b00, 0, 0, -1, 32'h0};

    rst_n = 1'b1; cl_valid = '0; rv = 0; rr = 0; hif.ht_ready_i = 1'b0;
    set_fixed_data();
    #1 rst_n = 1'b0;
    #2 check_rst("por");
    chk("por_ready", cl_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    hif.ht_ready_i = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      cl_valid = tbl[i].valid; hif.ht_ready_i = tbl[i].rdy;
      rv = tbl[i].pop; rr = tbl[i].pop;
      @(negedge clk);
      chk($sformatf("t%0d_ready", i), cl_ready, tbl[i].e_ready);
      chk($sformatf("t%0d_hv", i), hif.ht_valid_o, tbl[i].e_hv);
      chk($sformatf("t%0d_infl", i), inflight, tbl[i].e_infl);
      if (tbl[i].e_cid >= 0) chk($sformatf("t%0d_cid", i), res_cid, tbl[i].e_cid);
      if (tbl[i].e_hv) chk($sformatf("t%0d_key", i), hif.ht_key_o, tbl[i].e_key);
      @(posedge clk); model_update(); #1;
    end

    // stall with a task held in the output register
    do_reset();
    cl_valid = 2'b11; hif.ht_ready_i = 1'b0;
    cycle(1);
    repeat (5) cycle(1);
    chk("stall_key", hif.ht_key_o, 32'h01000000);
    chk("stall_val", hif.ht_value_o, 16'h1234);
    chk("stall_ready", cl_ready, 0);
    hif.ht_ready_i = 1'b1;
    #1 chk("resume_ready", cl_ready, 2'b10);
    cycle(1);
    chk("resume_key", hif.ht_key_o, 32'h02000000);

    // fill to MAX_INFLIGHT, one pop, refill
    do_reset();
    cl_valid = 2'b01;
    repeat (9) cycle(1);
    chk("full_infl", inflight, 8);
    chk("full_ready", cl_ready, 0);
    rv = 1; rr = 1;
    cycle(1);
    rv = 0; rr = 0;
    #1 chk("refill_ready", cl_ready, 2'b01);
    cycle(1);
    chk("refill_infl", inflight, 8);

    // simultaneous push and pop at inflight 3
    do_reset();
    cl_valid = 2'b11;
    repeat (3) cycle(1);
    chk("pp_pre_infl", inflight, 3);
    chk("pp_pre_cid", res_cid, 0);
    rv = 1; rr = 1;
    cycle(1);
    rv = 0; rr = 0; cl_valid = 2'b00;
    chk("pp_infl", inflight, 3);
    chk("pp_cid", res_cid, 1);

    // pop on empty, then asynchronous reset mid-burst
    do_reset();
    rv = 1; rr = 1;
    cycle(1);
    rv = 0; rr = 0;
    chk("err_set", err, 1);
    chk("err_infl", inflight, 0);
    cl_valid = 2'b10;
    repeat (3) cycle(1);
    chk("err_sticky", err, 1);
    chk("burst_infl", inflight, 3);
    chk("burst_cid", res_cid, 1);
    #2 rst_n = 1'b0;
    #1 check_rst("async");
    cl_valid = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cl_valid       = N'($urandom_range(0, 3));
      hif.ht_ready_i = ($urandom_range(0, 9) < 7);
      rv             = ($urandom_range(0, 9) < 5);
      rr             = ($urandom_range(0, 3) != 0);
      cl_key         = {$urandom, $urandom};
      cl_value       = {16'($urandom), 16'($urandom)};
      cl_cmd         = 4'($urandom);
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
